serial_adder: RTL and testbench

- Multi-cycle, parametrised successor to the single-bit full adder. Adds two WIDTH-bit operands plus a carry-in.
- Processes BPC bits per clock through an internal BPC-bit full-adder slice, with the carry held in a register between cycles.
- Used where area matters more than latency. Start/done handshake toward the controlling logic.
- Results: SUM, CARRY (unsigned carry-out) and OVERFLOW (two's-complement overflow).

---
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: BPC bits per cycle, result valid in the DONE cycle after WIDTH/BPC RUN edges.
// START is honoured only in IDLE/DONE, so a held START streams one operation every NCYC+1 cycles.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int NCYC = WIDTH / BPC;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_overflow;

  logic [BPC:0]         w_slice;
  logic                 w_c_msb;
  logic                 w_last;
  logic                 w_accept;
  logic [WIDTH+BPC-1:0] w_res_cat;
  logic [WIDTH-1:0]     w_res_next;

  assign w_slice  = {1'b0, r_a[BPC-1:0]} + {1'b0, r_b[BPC-1:0]} + {{BPC{1'b0}}, r_c};
  // Carry into the slice MSB recovered from its sum bit and operand bits.
  assign w_c_msb  = w_slice[BPC-1] ^ r_a[BPC-1] ^ r_b[BPC-1];
  assign w_last   = (r_cnt == CW'(NCYC - 1));
  assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign w_res_cat  = {w_slice[BPC-1:0], r_res};
  assign w_res_next = WIDTH'(w_res_cat >> BPC);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_start ? S_RUN : S_IDLE;
      S_RUN:   w_next = w_last ? S_DONE : S_RUN;
      S_DONE:  w_next = i_start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == S_RUN);
    o_done = (r_state == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_c        <= 1'b0;
      r_cnt      <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_c   <= i_cin;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> BPC;
      r_b   <= r_b >> BPC;
      r_res <= w_res_next;
      r_c   <= w_slice[BPC];
      if (w_last) begin
        r_sum      <= w_res_next;
        r_carry    <= w_slice[BPC];
        r_overflow <= w_c_msb ^ w_slice[BPC];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_sum      = r_sum;
  assign o_carry    = r_carry;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit BPC=1 scenarios plus exhaustive 4-bit runs at BPC=1,2,4.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry;
  logic       ovf;

  logic       e_start;
  logic [3:0] e_a;
  logic [3:0] e_b;
  logic       e_cin;
  logic       e1_busy, e2_busy, e4_busy;
  logic       e1_done, e2_done, e4_done;
  logic [3:0] e1_sum, e2_sum, e4_sum;
  logic       e1_carry, e2_carry, e4_carry;
  logic       e1_ovf, e2_ovf, e4_ovf;

  int n_pass;
  int n_chk;

  serial_adder #(.WIDTH(8), .BPC(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b), .i_cin(cin),
    .o_busy(busy), .o_done(done), .o_sum(sum), .o_carry(carry), .o_overflow(ovf)
  );

  serial_adder #(.WIDTH(4), .BPC(1)) u_e1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(e_start), .i_a(e_a), .i_b(e_b), .i_cin(e_cin),
    .o_busy(e1_busy), .o_done(e1_done), .o_sum(e1_sum), .o_carry(e1_carry), .o_overflow(e1_ovf)
  );

  serial_adder #(.WIDTH(4), .BPC(2)) u_e2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(e_start), .i_a(e_a), .i_b(e_b), .i_cin(e_cin),
    .o_busy(e2_busy), .o_done(e2_done), .o_sum(e2_sum), .o_carry(e2_carry), .o_overflow(e2_ovf)
  );

  serial_adder #(.WIDTH(4), .BPC(4)) u_e4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(e_start), .i_a(e_a), .i_b(e_b), .i_cin(e_cin),
    .o_busy(e4_busy), .o_done(e4_done), .o_sum(e4_sum), .o_carry(e4_carry), .o_overflow(e4_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one operation, scrambles the inputs during RUN, returns edges until DONE (0 = timeout).
  task automatic run_op(input logic [7:0] opa, input logic [7:0] opb, input logic opc,
                        output int lat);
    start = 1'b1; a = opa; b = opb; cin = opc;
    tick();
    start = 1'b0; a = ~opa; b = ~opb; cin = ~opc;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    e_start = 1'b0; e_a = 4'h0; e_b = 4'h0; e_cin = 1'b0;
    tick(); tick();
    n_chk++;
    if ({busy, done, carry, ovf, sum} !== 12'h000) $display("FAIL reset_8b: got busy=%b done=%b carry=%b ovf=%b sum=%h want all 0", busy, done, carry, ovf, sum);
    else n_pass++;
    n_chk++;
    if ({e1_busy, e1_done, e1_sum, e2_busy, e2_done, e2_sum, e4_busy, e4_done, e4_sum} !== 18'h0) $display("FAIL reset_4b: got nonzero outputs on 4-bit instances want 0");
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_chk++;
    if ({busy, done} !== 2'b00) $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_carry_out();
    int lat, bc;
    start = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b0;
    tick();
    start = 1'b0; a = 8'h00; b = 8'h00;
    lat = 0; bc = 0;
    for (int c = 0; c <= 20; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      if (busy) bc++;
      tick();
    end
    n_chk++;
    if (lat !== 8 || bc !== 8) $display("FAIL carry_latency: got done_at=%0d busy_cycles=%0d want 8 8", lat, bc);
    else n_pass++;
    n_chk++;
    if ({busy, carry, ovf, sum} !== {1'b0, 1'b1, 1'b0, 8'h00}) $display("FAIL carry_result: got busy=%b carry=%b ovf=%b sum=%h want 0 1 0 00", busy, carry, ovf, sum);
    else n_pass++;
    tick();
    n_chk++;
    if ({done, busy, carry, sum} !== {1'b0, 1'b0, 1'b1, 8'h00}) $display("FAIL done_pulse_hold: got done=%b busy=%b carry=%b sum=%h want 0 0 1 00", done, busy, carry, sum);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int lat;
    run_op(8'h7F, 8'h00, 1'b1, lat);
    n_chk++;
    if (lat !== 8 || {carry, ovf, sum} !== {1'b0, 1'b1, 8'h80}) $display("FAIL ovf_pos: got lat=%0d carry=%b ovf=%b sum=%h want 8 0 1 80", lat, carry, ovf, sum);
    else n_pass++;
    tick();
    run_op(8'h80, 8'h80, 1'b0, lat);
    n_chk++;
    if (lat !== 8 || {carry, ovf, sum} !== {1'b1, 1'b1, 8'h00}) $display("FAIL ovf_neg: got lat=%0d carry=%b ovf=%b sum=%h want 8 1 1 00", lat, carry, ovf, sum);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    int t1, gap;
    logic [7:0] mid_sum;
    start = 1'b1; a = 8'd3; b = 8'd4; cin = 1'b0;
    tick();
    a = 8'hF0; b = 8'h0F; cin = 1'b1;
    t1 = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done) begin
        t1 = c;
        break;
      end
    end
    n_chk++;
    if (t1 !== 8 || {carry, ovf, sum} !== {1'b0, 1'b0, 8'h07}) $display("FAIL b2b_first: got lat=%0d carry=%b ovf=%b sum=%h want 8 0 0 07", t1, carry, ovf, sum);
    else n_pass++;
    gap = 0; mid_sum = 8'hxx;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 3) mid_sum = sum;
      if (done) begin
        gap = c;
        break;
      end
    end
    start = 1'b0;
    n_chk++;
    if (mid_sum !== 8'h07) $display("FAIL b2b_hold: got sum=%h mid-run want 07", mid_sum);
    else n_pass++;
    n_chk++;
    if (gap !== 9 || {carry, ovf, sum} !== {1'b1, 1'b0, 8'h00}) $display("FAIL b2b_second: got gap=%0d carry=%b ovf=%b sum=%h want 9 1 0 00", gap, carry, ovf, sum);
    else n_pass++;
    tick();
    n_chk++;
    if ({done, busy} !== 2'b00) $display("FAIL b2b_idle: got done=%b busy=%b want 0 0", done, busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int lat, dcnt;
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, carry, ovf, sum} !== 12'h000) $display("FAIL abort_outputs: got busy=%b done=%b carry=%b ovf=%b sum=%h want all 0", busy, done, carry, ovf, sum);
    else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done || busy) dcnt++;
    end
    n_chk++;
    if (dcnt !== 0) $display("FAIL abort_no_done: got %0d active cycles want 0", dcnt);
    else n_pass++;
    run_op(8'h12, 8'h34, 1'b0, lat);
    n_chk++;
    if (lat !== 8 || {carry, ovf, sum} !== {1'b0, 1'b0, 8'h46}) $display("FAIL abort_restart: got lat=%0d carry=%b ovf=%b sum=%h want 8 0 0 46", lat, carry, ovf, sum);
    else n_pass++;
    tick();
  endtask

  task automatic test_exhaustive_w4();
    int l1, l2, l4, s;
    logic [5:0] r1, r2, r4, ex;
    logic [3:0] ea, eb;
    logic ec, eo;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          ea = 4'(ia); eb = 4'(ib); ec = (ic != 0);
          s = ia + ib + ic;
          eo = (ea[3] == eb[3]) && (4'(s) >> 3 != {3'b000, ea[3]});
          ex = {(s > 15), eo, 4'(s)};
          e_a = ea; e_b = eb; e_cin = ec; e_start = 1'b1;
          tick();
          e_start = 1'b0; e_a = ~ea; e_b = ~eb; e_cin = ~ec;
          l1 = 0; l2 = 0; l4 = 0; r1 = '0; r2 = '0; r4 = '0;
          for (int c = 1; c <= 6; c++) begin
            tick();
            if (e1_done && l1 == 0) begin l1 = c; r1 = {e1_carry, e1_ovf, e1_sum}; end
            if (e2_done && l2 == 0) begin l2 = c; r2 = {e2_carry, e2_ovf, e2_sum}; end
            if (e4_done && l4 == 0) begin l4 = c; r4 = {e4_carry, e4_ovf, e4_sum}; end
          end
          n_chk++;
          if (l1 !== 4 || r1 !== ex) $display("FAIL exh_bpc1 a=%h b=%h c=%b: got lat=%0d {c,v,s}=%h want 4 %h", ea, eb, ec, l1, r1, ex);
          else n_pass++;
          n_chk++;
          if (l2 !== 2 || r2 !== ex) $display("FAIL exh_bpc2 a=%h b=%h c=%b: got lat=%0d {c,v,s}=%h want 2 %h", ea, eb, ec, l2, r2, ex);
          else n_pass++;
          n_chk++;
          if (l4 !== 1 || r4 !== ex) $display("FAIL exh_bpc4 a=%h b=%h c=%b: got lat=%0d {c,v,s}=%h want 1 %h", ea, eb, ec, l4, r4, ex);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    test_reset();
    test_carry_out();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    test_exhaustive_w4();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
